md_unit: RTL
============

Name: md_unit

Overview:
Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU as multi-cycle operations. Serves MFHI/MFLO reads and MTHI/MTLO writes. Drives the busy signal that the D-stage stall controller consumes as E_HILObusy, so the stall controller can freeze D while HI/LO is in use.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family when enabled); must be ≥1.
DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be ≥1.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low; 0 at a rising edge resets the unit.
start  in  1  E-stage instruction is an MD-class op; qualifies md_op.
md_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; 13–15 are NONE.
A  in  32  forwarded rs value.
B  in  32  forwarded rt value.
busy  out  1  to stall controller (E_HILObusy).
HI  out  32  current HI register.
LO  out  32  current LO register.
out  out  32  MFHI/MFLO read data for the E→M result mux.

Behaviour:
- Reset (reset==0 at an edge): HI=0, LO=0, counter=0, busy_reg=0, pending result cleared. Any in-flight operation is aborted, with no write-back. busy=0 from the next cycle, unless start is high with an arithmetic op.
- Arithmetic op = MULT/MULTU/DIV/DIVU, plus the MADD family when enabled.
- Accept: at edge e0, if reset==1, start==1, busy_reg==0 and md_op is arithmetic:
  - latch the operands;
  - compute the 64-bit result into a pending register;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - set busy_reg=1.
- busy = busy_reg | (start & arithmetic op & ~busy_reg). It is combinational, so it is high in the issue cycle itself.
- Count: each edge with busy_reg==1 decrements the counter. At the edge where the counter goes 1→0, HI/LO take the pending result and busy_reg clears. Result: HI/LO change exactly at edge e0+N, and busy is high for N+1 cycles counting the issue cycle.
- Results:
  - MULT: signed 64-bit product; MULTU: unsigned. HI=[63:32], LO=[31:0].
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU: unsigned.
  - Divide by zero (B==0): the operation still takes DIV_CYCLES, but HI/LO are left unchanged at completion.
- Ops arriving while busy_reg==1 (all op types): ignored. The stall controller prevents this; the unit must not corrupt state if it happens.
- MTHI/MTLO: with start==1 and busy_reg==0, HI<=A or LO<=A at the edge. Single cycle; busy stays 0.
- MFHI/MFLO: out=HI or LO combinationally; out=0 for every other op. No state change.
- Reset takes priority over accept, completion and MT writes in the same edge.
- Completion edge with start==1 and an arithmetic op: the new op is not accepted, because busy_reg is still 1 at that edge. It is re-presented next cycle under stall.

Optional Feature:
MD_MADD_EN
- Defined: md_op 9–12 are arithmetic ops with MULT_CYCLES latency. At completion {HI,LO} <= {HI,LO} ± product, using a 64-bit wrap-around add/sub.
  - MADD/MSUB use a signed product; MADDU/MSUBU use unsigned.
  - The accumulate uses the HI/LO value at completion time.
- Undefined: md_op 9–12 are NONE. They never raise busy and never write HI/LO.

Test Plan:
- MULT with A=0xFFFFFFFD, B=5 → busy high 6 cycles. HI=0xFFFFFFFF, LO=0xFFFFFFF1 at edge e0+5; unchanged before that edge.
- MULTU with A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE. Then DIV with A=0xFFFFFFF9 (−7), B=2 → busy 11 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with A=7, B=2 → LO=3, HI=1.
- MTHI A=0x12345678, then MFHI next cycle → out=0x12345678, busy never asserted. DIVU with B=0 → busy 11 cycles, HI/LO unchanged.
- Start MULT, then a different MULT and an MTLO presented while busy_reg=1 → both ignored; only the first product is written.
- Start DIV, pull reset=0 at cycle 4 → HI=LO=0, busy=0 next cycle, no later write. Start MULT in the same edge reset is low → not accepted.
- With MD_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 → HI=1, LO=0. Without the macro, md_op=10 → busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit for the MIPS E stage. Results land in HI/LO after a fixed busy latency.
// Define MD_MADD_EN to add MADD/MADDU/MSUB/MSUBU (accumulate into HI/LO at completion).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  // How the pending result is applied to HI/LO when the counter expires.
  typedef enum logic [1:0] {WB_SET, WB_SKIP, WB_ADD, WB_SUB} wb_mode_e;

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      pend_q, pend_d;
  wb_mode_e         mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_reg_q, busy_reg_d;

  logic             is_arith;
  logic             is_div;
  logic             signed_op;
  wb_mode_e         arith_mode;
  logic [63:0]      prod_s, prod_u, arith_res;
  logic [31:0]      a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic             accept;

  always_comb begin
    is_arith   = 1'b0;
    is_div     = 1'b0;
    signed_op  = 1'b0;
    arith_mode = WB_SET;
    case (md_op)
      OP_MULT:  begin is_arith = 1'b1; signed_op = 1'b1; end
      OP_MULTU: begin is_arith = 1'b1; end
      OP_DIV:   begin is_arith = 1'b1; is_div = 1'b1; signed_op = 1'b1; end
      OP_DIVU:  begin is_arith = 1'b1; is_div = 1'b1; end
      OP_MADD:  begin is_arith = MADD_EN; signed_op = 1'b1; arith_mode = WB_ADD; end
      OP_MADDU: begin is_arith = MADD_EN; arith_mode = WB_ADD; end
      OP_MSUB:  begin is_arith = MADD_EN; signed_op = 1'b1; arith_mode = WB_SUB; end
      OP_MSUBU: begin is_arith = MADD_EN; arith_mode = WB_SUB; end
      default:  ;
    endcase
  end

  // Signed divide is done on magnitudes so the most-negative / -1 case wraps cleanly.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    a_mag  = (signed_op && A[31]) ? -A : A;
    b_mag  = (signed_op && B[31]) ? -B : B;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (signed_op && (A[31] ^ B[31])) ? -q_mag : q_mag;
    rem    = (signed_op && A[31]) ? -r_mag : r_mag;
    if (is_div) arith_res = {rem, quo};
    else if (signed_op) arith_res = prod_s;
    else arith_res = prod_u;
  end

  assign accept = start & ~busy_reg_q & is_arith;
  assign busy   = busy_reg_q | accept;
  assign HI     = hi_q;
  assign LO     = lo_q;

  always_comb begin
    out = 32'd0;
    if (start) begin
      case (md_op)
        OP_MFHI: out = hi_q;
        OP_MFLO: out = lo_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_d     = pend_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    busy_reg_d = busy_reg_q;
    if (busy_reg_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_reg_d = 1'b0;
        case (mode_q)
          WB_SET:  {hi_d, lo_d} = pend_q;
          WB_ADD:  {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
          WB_SUB:  {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
          default: ;
        endcase
      end
    end else if (accept) begin
      pend_d     = arith_res;
      mode_d     = (is_div && (B == 32'd0)) ? WB_SKIP : arith_mode;
      cnt_d      = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy_reg_d = 1'b1;
    end else if (start && (md_op == OP_MTHI)) begin
      hi_d = A;
    end else if (start && (md_op == OP_MTLO)) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      pend_q     <= 64'd0;
      mode_q     <= WB_SET;
      cnt_q      <= '0;
      busy_reg_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_q     <= pend_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      busy_reg_q <= busy_reg_d;
    end
  end

endmodule
